fifo_srl_param: RTL and testbench
=================================

// Module: fifo_srl_param
// PURPOSE
//  Parametrised SRL16/SRLC32-style shift-register FIFO, first-word-fall-through.
//  Successor to the fixed 16x32 FIFO used between DSP stages and host/data paths.
//  Adds:
//   - generic width and depth
//   - fill level output
//   - programmable almost-full / almost-empty flags
//   - synchronous flush
//   - sticky overflow/underflow error flags with clear
// PARAMETERS
//  WIDTH    32   data width in bits
//  AW       4    address width; capacity DEPTH = 2**AW - 1 entries (AW=4 -> 15, AW=5 -> 31)
//  AF_LEVEL 12   almost_full asserted when level >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL 2    almost_empty asserted when level <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous active-high reset
//  pdi       in   WIDTH  write data
//  iv        in   1      input valid (write request)
//  oe        in   1      output enable (read request)
//  flush     in   1      synchronous flush; discards all contents
//  clr_err   in   1      clears ovf/udf sticky flags
//  pdo       out  WIDTH  head-of-FIFO data (valid whenever empty=0)
//  ov        out  1      output valid: read accepted this cycle (oe & ~empty)
//  empty     out  1      no entries
//  full      out  1      DEPTH entries
//  afull     out  1      almost full
//  aempty    out  1      almost empty
//  level     out  AW     current entry count, 0..DEPTH
//  ovf       out  1      sticky: iv asserted while full
//  udf       out  1      sticky: oe asserted while empty
// BEHAVIOUR
//  Interface: one clock (clk); reset rst is synchronous and active-high. Priority: rst > flush > normal operation.
//  Storage: DEPTH x WIDTH shift register. When we=1, pdi shifts into tap 0 and all taps move up one.
//   Storage is not reset.
//  Pointer: addr[AW-1:0] is the tap of the oldest entry; all-ones = empty.
//   - Reset/flush: addr <= all-ones.
//   - Update: addr += 1 on we&~ov; addr -= 1 on ov&~we; unchanged on both or neither (mod 2**AW).
//  we = iv & ~full. Writes while full are dropped, even if oe=1 in the same cycle.
//  ov = oe & ~empty (combinational). pdo = storage[addr] (combinational mux from registered addr).
//  level  = addr + 1 (mod 2**AW)
//  empty  = (addr == all-ones)
//  full   = (addr == DEPTH-1)
//  afull  = (level >= AF_LEVEL)
//  aempty = (level <= AE_LEVEL)
//   All four flags decode from registered state: no added latency.
//  Latency: word written in cycle N (FIFO empty) appears on pdo with empty=0 in cycle N+1.
//  Boundary cases:
//   - iv&oe while empty: write only, ov=0, udf set.
//   - iv&oe while full: read only, ov=1, ovf set, level -> DEPTH-1.
//   - iv&oe otherwise: level unchanged; order preserved.
//  Sticky flags:
//   - ovf sets on iv&full; udf sets on oe&empty.
//   - Both cleared by rst or clr_err. Set wins over clr_err in the same cycle.
//   - flush does not clear ovf/udf.
//  flush:
//   - iv/oe ignored that cycle: no write, ov=0, ovf/udf do not set.
//   - Next cycle: empty=1, level=0.
//  Reset values: empty=1, full=0, level=0, aempty=1, afull=0, ov=0, ovf=0, udf=0.
//   pdo is undefined while empty=1 and must not be checked.
//  Reset mid-operation: contents discarded; FIFO reads empty from the next cycle.
// TESTING (WIDTH=32, AW=4, AF_LEVEL=12, AE_LEVEL=2)
//  1 Reset:
//    rst 1 cycle -> empty=1, level=0, aempty=1, afull=0, ov=0, ovf=udf=0.
//  2 Fill:
//    write 0x1..0xF on 15 cycles -> afull at level 12, full at 15, aempty drops at level 3.
//    16th iv -> level stays 15, ovf=1.
//  3 Drain:
//    oe held 16 cycles -> pdo 0x1..0xF in order with ov=1, then empty=1, ov=0, udf=1.
//    clr_err -> udf=0.
//  4 Concurrent:
//    at level 5, iv&oe for 10 cycles -> level stays 5, output order strictly FIFO.
//    iv&oe while empty -> ov=0, level 1, next cycle pdo=written word.
//    iv&oe while full -> ov=1, level 14, written word dropped.
//  5 Flush/reset:
//    at level 8, flush with iv=1 -> next cycle level=0, empty=1, no write, ovf unchanged.
//    rst at level 9 -> same, and ovf/udf cleared.
//  6 Random:
//    10k cycles of random iv/oe/flush vs. queue model -> pdo/ov/level/flags match every cycle.

Source files
------------

// File: rtl/fifo_srl_param_if.sv
// rtl/fifo_srl_param_if.sv - data/flag bundle between a producer/consumer and the SRL FIFO
interface fifo_srl_param_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
);
  logic [WIDTH-1:0] pdi;
  logic             iv;
  logic             oe;
  logic             flush;
  logic             clr_err;
  logic [WIDTH-1:0] pdo;
  logic             ov;
  logic             empty;
  logic             full;
  logic             afull;
  logic             aempty;
  logic [AW-1:0]    level;
  logic             ovf;
  logic             udf;

  modport master (
    output pdi, iv, oe, flush, clr_err,
    input  pdo, ov, empty, full, afull, aempty, level, ovf, udf
  );

  modport slave (
    input  pdi, iv, oe, flush, clr_err,
    output pdo, ov, empty, full, afull, aempty, level, ovf, udf
  );
endinterface

// File: rtl/fifo_srl_param.sv
// rtl/fifo_srl_param.sv - shift-register FWFT FIFO, DEPTH = 2**AW-1, with level, flags and sticky errors
module fifo_srl_param #(
  parameter int WIDTH    = 32,
  parameter int AW       = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input logic            clk,
  input logic            rst,
  fifo_srl_param_if.slave bus
);
  localparam int DEPTH = (1 << AW) - 1;
  localparam logic [AW-1:0] ADDR_EMPTY = '1;
  localparam logic [AW-1:0] ADDR_FULL  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] AF_L       = AW'(AF_LEVEL);
  localparam logic [AW-1:0] AE_L       = AW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    addr_q, addr_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic          empty_w, full_w, we, rd;
  logic [AW-1:0] level_w;

  // addr points at the oldest tap; all-ones means nothing stored
  assign empty_w = (addr_q == ADDR_EMPTY);
  assign full_w  = (addr_q == ADDR_FULL);
  assign level_w = addr_q + AW'(1);
  assign we      = bus.iv & ~full_w & ~bus.flush;
  assign rd      = bus.oe & ~empty_w & ~bus.flush;

  always_comb begin
    addr_d = addr_q;
    if (bus.flush) begin
      addr_d = ADDR_EMPTY;
    end else if (we && !rd) begin
      addr_d = addr_q + AW'(1);
    end else if (rd && !we) begin
      addr_d = addr_q - AW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[0] = bus.pdi;
      for (int i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  // a new error event in the same cycle as clr_err keeps the flag set
  always_comb begin
    ovf_d = (bus.iv & full_w & ~bus.flush) | (ovf_q & ~bus.clr_err);
    udf_d = (bus.oe & empty_w & ~bus.flush) | (udf_q & ~bus.clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= ADDR_EMPTY;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign bus.pdo    = empty_w ? '0 : mem_q[addr_q];
  assign bus.ov     = rd;
  assign bus.empty  = empty_w;
  assign bus.full   = full_w;
  assign bus.afull  = (level_w >= AF_L);
  assign bus.aempty = (level_w <= AE_L);
  assign bus.level  = level_w;
  assign bus.ovf    = ovf_q;
  assign bus.udf    = udf_q;
endmodule

// File: tb/tb_fifo_srl_param.sv
// tb/tb_fifo_srl_param.sv - scoreboard bench: directed scenarios plus 10k random cycles vs a queue model
module tb_fifo_srl_param;
  localparam int WIDTH = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 15;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_srl_param_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  fifo_srl_param #(.WIDTH(WIDTH), .AW(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q [$];
  bit ovf_m, udf_m, chk_en;

  bit          p_valid, p_rst, p_flush, p_clr, p_push, p_ovf_set, p_udf_set;
  logic [31:0] p_data;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // apply the effect of the cycle that just ended to the model
  task automatic commit();
    if (!p_valid) return;
    if (p_rst) begin
      exp_q.delete();
      ovf_m  = 1'b0;
      udf_m  = 1'b0;
      chk_en = 1'b1;
    end else begin
      if (p_flush) exp_q.delete();
      else if (p_push) exp_q.push_back(p_data);
      ovf_m = p_ovf_set | (ovf_m & ~p_clr);
      udf_m = p_udf_set | (udf_m & ~p_clr);
    end
  endtask

  task automatic cycle(bit iv, bit oe, bit fl, bit clr, bit r, logic [31:0] d);
    bit m_full, m_empty;
    @(posedge clk);
    commit();
    #1;
    bus.iv = iv; bus.oe = oe; bus.flush = fl; bus.clr_err = clr; bus.pdi = d; rst = r;
    m_full    = (exp_q.size() == DEPTH);
    m_empty   = (exp_q.size() == 0);
    p_valid   = 1'b1;
    p_rst     = r;
    p_flush   = fl;
    p_clr     = clr;
    p_data    = d;
    p_push    = iv & !m_full & !fl;
    p_ovf_set = iv & m_full & !fl;
    p_udf_set = oe & m_empty & !fl;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  int          mon_n;
  bit          mon_ov;
  // monitor: compares every visible output to the model; pops the scoreboard on each accepted read
  always @(negedge clk) begin
    if (chk_en) begin
      mon_n  = exp_q.size();
      mon_ov = bus.oe & (mon_n > 0) & !bus.flush;
      chk("ov", 32'(bus.ov), 32'(mon_ov));
      chk("level", 32'(bus.level), 32'(mon_n));
      chk("empty", 32'(bus.empty), 32'(mon_n == 0));
      chk("full", 32'(bus.full), 32'(mon_n == DEPTH));
      chk("afull", 32'(bus.afull), 32'(mon_n >= AF));
      chk("aempty", 32'(bus.aempty), 32'(mon_n <= AE));
      chk("ovf", 32'(bus.ovf), 32'(ovf_m));
      chk("udf", 32'(bus.udf), 32'(udf_m));
      if (mon_n > 0) chk("pdo", bus.pdo, exp_q[0]);
      if (mon_ov) void'(exp_q.pop_front());
    end
  end

  logic [31:0] wd;
  int          pct;

  initial begin
    bus.iv = 0; bus.oe = 0; bus.flush = 0; bus.clr_err = 0; bus.pdi = '0;
    p_valid = 0; chk_en = 0;

    cycle(0, 0, 0, 0, 1, 32'h0);
    idle();
    at_neg();
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_aempty", 32'(bus.aempty), 32'd1);
    chk("rst_afull", 32'(bus.afull), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);

    for (int i = 1; i <= 15; i++) cycle(1, 0, 0, 0, 0, 32'(i));
    cycle(1, 0, 0, 0, 0, 32'h10);
    idle();
    at_neg();
    chk("fill_level", 32'(bus.level), 32'd15);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_ovf", 32'(bus.ovf), 32'd1);

    for (int i = 1; i <= 16; i++) begin
      cycle(0, 1, 0, 0, 0, 32'h0);
      at_neg();
      if (i <= 15) chk("drain_pdo", bus.pdo, 32'(i));
      else chk("drain_ov_end", 32'(bus.ov), 32'd0);
    end
    idle();
    at_neg();
    chk("drain_udf", 32'(bus.udf), 32'd1);
    cycle(0, 0, 0, 1, 0, 32'h0);
    idle();
    at_neg();
    chk("clr_udf", 32'(bus.udf), 32'd0);
    chk("clr_ovf", 32'(bus.ovf), 32'd0);

    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, $urandom);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 0, $urandom);
    idle();
    at_neg();
    chk("conc_level", 32'(bus.level), 32'd5);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 32'h0);
    cycle(1, 1, 0, 0, 0, 32'hCAFE_0001);
    at_neg();
    chk("conc_empty_ov", 32'(bus.ov), 32'd0);
    idle();
    at_neg();
    chk("conc_empty_level", 32'(bus.level), 32'd1);
    chk("conc_empty_pdo", bus.pdo, 32'hCAFE_0001);
    for (int i = 0; i < 14; i++) cycle(1, 0, 0, 0, 0, $urandom);
    cycle(1, 1, 0, 0, 0, 32'hDEAD_BEEF);
    at_neg();
    chk("conc_full_ov", 32'(bus.ov), 32'd1);
    idle();
    at_neg();
    chk("conc_full_level", 32'(bus.level), 32'd14);
    chk("conc_full_ovf", 32'(bus.ovf), 32'd1);

    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 0, 32'h0);
    cycle(1, 1, 1, 0, 0, 32'h1234_5678);
    at_neg();
    chk("flush_ov", 32'(bus.ov), 32'd0);
    idle();
    at_neg();
    chk("flush_level", 32'(bus.level), 32'd0);
    chk("flush_empty", 32'(bus.empty), 32'd1);
    chk("flush_ovf", 32'(bus.ovf), 32'd1);

    cycle(0, 1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 9; i++) cycle(1, 0, 0, 0, 0, $urandom);
    cycle(1, 0, 0, 0, 1, 32'h0);
    idle();
    at_neg();
    chk("rst2_level", 32'(bus.level), 32'd0);
    chk("rst2_empty", 32'(bus.empty), 32'd1);
    chk("rst2_ovf", 32'(bus.ovf), 32'd0);
    chk("rst2_udf", 32'(bus.udf), 32'd0);

    for (int i = 0; i < 10000; i++) begin
      pct = ((i / 400) % 2 == 0) ? 75 : 30;
      wd  = $urandom;
      cycle($urandom_range(99) < pct, $urandom_range(99) < (100 - pct),
            $urandom_range(63) == 0, $urandom_range(15) == 0,
            $urandom_range(255) == 0, wd);
    end
    idle();
    idle();
    at_neg();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
